hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed hazard-detection and forwarding logic of the 5-stage MIPS pipeline.
- Tracks in-flight register writes across a configurable number of post-decode stages, plus one variable-latency multicycle unit (MUL/DIV).
- Produces the ID-stage stall and the forwarding selects, both for early (ID-stage branch/jr) operands and for registered EX-stage operands.
- Sits beside the decode stage; the EX/MEM/WB datapath muxes consume its select outputs.

Parameters:
AW, 5, register-address width (2**AW architectural registers; register 0 hard-wired zero)
DEPTH, 3, post-decode tracked stages (slot 0 = EX, slot DEPTH-1 = WB); legal range 2..6
SW, 3, width of forwarding-select outputs; must satisfy 2**SW > DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
id_valid  in  1  instruction present in ID
id_rs, id_rt  in  AW  source register addresses
id_rs_use, id_rt_use  in  1  source actually read
id_early  in  1  operands needed in ID (branch/jr) rather than EX
id_wr_en  in  1  instruction writes a register
id_wr_reg  in  AW  destination register
id_avail  in  SW  slot at whose end the result exists (0 = ALU, 1 = load)
id_multi  in  1  instruction issues to the multicycle unit
flush  in  1  kill the ID instruction (does not enter slot 0)
mc_done  in  1  multicycle result written this cycle
stall  out  1  hold PC and IF/ID, inject bubble
id_fwd_rs, id_fwd_rt  out  SW  ID-stage select: 0 = regfile, k = slot k-1
ex_fwd_rs, ex_fwd_rt  out  SW  registered EX-stage select, same encoding
mc_busy  out  1  multicycle unit occupied

Behaviour:
- Slots: each holds valid, reg, avail. Every cycle the pipeline shifts by one: slot k+1 <= slot k, and the last slot's entry retires.
- Slot 0 loads the ID instruction when id_valid & !stall & !flush; otherwise it loads a bubble (valid = 0).
- An entry matches a source when valid & wr_en & reg == src & src != 0 & src_use. The youngest match (lowest k) wins.
- Normal consumer (id_early = 0):
  - Match at slot k with k >= avail: forward; ex_fwd latches k+2 on advance, since the producer sits in slot k+1 next cycle.
  - k < avail: stall.
  - Producer that would retire before EX: select 0.
- Early consumer (id_early = 1):
  - Match with k > avail: id_fwd = k+1.
  - k <= avail: stall.
- Multicycle unit:
  - busy[reg] is set when a multi instruction advances into slot 0.
  - mc_busy = OR of busy. mc_done clears busy[mc_reg] (tracked internally from the issuing id_wr_reg).
- Additional stall conditions:
  - Source register busy (RAW).
  - id_wr_reg busy (WAW).
  - id_multi while mc_busy (single unit).
- Simultaneous events:
  - mc_done in the same cycle a consumer checks the busy register: no stall.
  - flush with stall: flush wins; slot 0 takes a bubble and stall is still reported.
- ex_fwd_* holds its value while stall = 1; the EX-bound instruction is a bubble, so the value is ignored.
- Reset (any time, including mid multicycle op): all slots invalid, busy = 0, stall = 0, all selects = 0, mc_busy = 0.
- All outputs except ex_fwd_* are combinational from state and ID inputs.

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt (32-bit): counts cycles with stall = 1.
  - mc_stall_cnt (32-bit): counts stalls caused solely by busy bits.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, neither port nor counters exist and behaviour is otherwise identical.

Test Plan:
- ALU-to-ALU (DEPTH = 3): add r3 issued, then next cycle add r4 using r3 (avail = 0) -> stall = 0; ex_fwd_rs = 2 the following cycle.
- Load-use: lw r5 (avail = 1), then add using r5 -> exactly 1 stall cycle, then ex_fwd_rs = 3.
- Early branch on r3 right after add r3 (avail = 0) -> 1 stall cycle, then id_fwd_rs = 2. Branch on r0 -> never stalls.
- Multicycle: mul r8 issued; consumer of r8 stalls until mc_done; at mc_done cycle stall = 0. A second mul while busy also stalls.
- Flush during stall -> slot 0 gets a bubble, no busy bit set. Asserting rst mid-mul clears mc_busy and stall within the same cycle (asynchronous).
- STATS_EN: 5 load-use pairs -> stall_cnt = 5; 10-cycle mul dependency -> mc_stall_cnt = 10.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside ID: tracks in-flight writes and the multicycle unit, and drives stall/forwarding selects.
// Optional stall counters enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_use,
  input  logic          id_rt_use,
  input  logic          id_early,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_wr_reg,
  input  logic [SW-1:0] id_avail,
  input  logic          id_multi,
  input  logic          flush,
  input  logic          mc_done,
  output logic          stall,
  output logic [SW-1:0] id_fwd_rs,
  output logic [SW-1:0] id_fwd_rt,
  output logic [SW-1:0] ex_fwd_rs,
  output logic [SW-1:0] ex_fwd_rt,
  output logic          mc_busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   mc_stall_cnt
`endif
);
  localparam int unsigned NREG = 1 << AW;

  logic            slot_vld [DEPTH];
  logic [AW-1:0]   slot_reg [DEPTH];
  logic [SW-1:0]   slot_avl [DEPTH];
  logic [NREG-1:0] busy_q;
  logic [AW-1:0]   mc_reg_q;

  logic [1:0][AW-1:0] src;
  logic [1:0]         src_use;
  logic [1:0]         src_hz;
  logic [1:0]         src_hit;
  logic [1:0][SW-1:0] id_sel;
  logic [1:0][SW-1:0] ex_sel;

  logic [NREG-1:0] done_mask;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] issue_mask;
  logic            raw_hz;
  logic            waw_hz;
  logic            unit_hz;
  logic            mc_hz;
  logic            slot_hz;
  logic            advance;

  // Youngest matching slot decides forward vs stall for each source
  always_comb begin
    src     = {id_rt, id_rs};
    src_use = {id_rt_use, id_rs_use};
    src_hz  = '0;
    src_hit = '0;
    id_sel  = '0;
    ex_sel  = '0;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (!src_hit[j] && id_valid && src_use[j] && src[j] != '0 &&
            slot_vld[k] && slot_reg[k] == src[j]) begin
          src_hit[j] = 1'b1;
          if (id_early) begin
            if (SW'(k) > slot_avl[k]) id_sel[j] = SW'(k + 1);
            else                      src_hz[j] = 1'b1;
          end else if (SW'(k) < slot_avl[k]) begin
            src_hz[j] = 1'b1;
          end else if (k < int'(DEPTH) - 1) begin
            ex_sel[j] = SW'(k + 2);
          end
        end
      end
    end
  end

  // A completion this cycle already frees its register for the ID check
  always_comb begin
    done_mask  = mc_done ? (NREG'(1) << mc_reg_q) : '0;
    busy_eff   = busy_q & ~done_mask;
    raw_hz     = (id_rs_use && id_rs != '0 && busy_eff[id_rs]) ||
                 (id_rt_use && id_rt != '0 && busy_eff[id_rt]);
    waw_hz     = id_wr_en && busy_eff[id_wr_reg];
    unit_hz    = id_multi && (busy_eff != '0);
    mc_hz      = id_valid && (raw_hz || waw_hz || unit_hz);
    slot_hz    = src_hz != '0;
    stall      = slot_hz || mc_hz;
    advance    = id_valid && !stall && !flush;
    issue_mask = (advance && id_multi) ? (NREG'(1) << id_wr_reg) : '0;
  end

  assign mc_busy   = busy_q != '0;
  assign id_fwd_rs = id_sel[0];
  assign id_fwd_rt = id_sel[1];

  // Multicycle results never forward from the slots, so they enter slot 0 as non-writers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        slot_vld[k] <= 1'b0;
        slot_reg[k] <= '0;
        slot_avl[k] <= '0;
      end
      busy_q    <= '0;
      mc_reg_q  <= '0;
      ex_fwd_rs <= '0;
      ex_fwd_rt <= '0;
    end else begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        slot_vld[k] <= slot_vld[k-1];
        slot_reg[k] <= slot_reg[k-1];
        slot_avl[k] <= slot_avl[k-1];
      end
      slot_vld[0] <= advance && id_wr_en && !id_multi;
      slot_reg[0] <= id_wr_reg;
      slot_avl[0] <= id_avail;
      busy_q      <= busy_eff | issue_mask;
      if (advance && id_multi) mc_reg_q <= id_wr_reg;
      if (!stall) begin
        ex_fwd_rs <= ex_sel[0];
        ex_fwd_rt <= ex_sel[1];
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  // Saturating stall counters; mc_stall_cnt counts stalls with no slot hazard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt    <= '0;
      mc_stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (mc_hz && !slot_hz && mc_stall_cnt != '1) mc_stall_cnt <= mc_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against an age-indexed reference model.
// Counter checks are included when HAZARD_SCOREBOARD_STATS_EN is defined.
module tb_hazard_scoreboard;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned SW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs_use, id_rt_use, id_early, id_wr_en, id_multi, flush, mc_done;
  logic [AW-1:0] id_rs, id_rt, id_wr_reg;
  logic [SW-1:0] id_avail;
  logic          stall, mc_busy;
  logic [SW-1:0] id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0]   stall_cnt, mc_stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_early(id_early),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_avail(id_avail),
    .id_multi(id_multi), .flush(flush), .mc_done(mc_done), .stall(stall),
    .id_fwd_rs(id_fwd_rs), .id_fwd_rt(id_fwd_rt), .ex_fwd_rs(ex_fwd_rs),
    .ex_fwd_rt(ex_fwd_rt), .mc_busy(mc_busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    , .stall_cnt(stall_cnt), .mc_stall_cnt(mc_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: q[a] is the instruction that entered EX a cycles ago
  typedef struct packed { logic wr; logic [AW-1:0] rd; logic [SW-1:0] av; } ent_t;
  ent_t          q[$];
  bit            mc_pend;
  logic [AW-1:0] mc_dst;
  logic [SW-1:0] m_ex_rs, m_ex_rt;
  int unsigned   m_stall_cnt, m_mc_cnt;

  function automatic void eval_src(input logic [AW-1:0] s, input logic u, output bit hz,
                                   output logic [SW-1:0] idsel, output logic [SW-1:0] exsel);
    hz = 0; idsel = '0; exsel = '0;
    if (!id_valid || !u || s == '0) return;
    for (int a = 0; a < q.size(); a++) begin
      if (q[a].wr && q[a].rd == s) begin
        if (id_early) begin
          if (a > int'(q[a].av)) idsel = SW'(a + 1);
          else hz = 1;
        end else if (a < int'(q[a].av)) begin
          hz = 1;
        end else if (a + 1 < int'(DEPTH)) begin
          exsel = SW'(a + 2);  // producer sits one slot older once the consumer is in EX
        end
        return;
      end
    end
  endfunction

  function automatic void eval_all(output bit st, output bit mc_only,
                                   output logic [SW-1:0] irs, output logic [SW-1:0] irt,
                                   output logic [SW-1:0] ers, output logic [SW-1:0] ert);
    bit hs, ht, bhz, pend;
    eval_src(id_rs, id_rs_use, hs, irs, ers);
    eval_src(id_rt, id_rt_use, ht, irt, ert);
    pend = mc_pend && !mc_done;
    bhz  = id_valid && pend && ((id_rs_use && id_rs != '0 && id_rs == mc_dst) ||
                                (id_rt_use && id_rt != '0 && id_rt == mc_dst) ||
                                (id_wr_en && id_wr_reg == mc_dst) || id_multi);
    st      = hs || ht || bhz;
    mc_only = bhz && !(hs || ht);
  endfunction

  bit            u_st, u_mco, adv;
  logic [SW-1:0] u_irs, u_irt, u_ers, u_ert;
  ent_t          ent;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      mc_pend = 0; mc_dst = '0; m_ex_rs = '0; m_ex_rt = '0;
      m_stall_cnt = 0; m_mc_cnt = 0;
    end else begin
      eval_all(u_st, u_mco, u_irs, u_irt, u_ers, u_ert);
      adv    = id_valid && !u_st && !flush;
      ent.wr = adv && id_wr_en && !id_multi;
      ent.rd = id_wr_reg;
      ent.av = id_avail;
      q.push_front(ent);
      while (q.size() > int'(DEPTH)) void'(q.pop_back());
      if (mc_done) mc_pend = 0;
      if (adv && id_multi) begin mc_pend = 1; mc_dst = id_wr_reg; end
      if (!u_st) begin m_ex_rs = u_ers; m_ex_rt = u_ert; end
      if (u_st) m_stall_cnt++;
      if (u_mco) m_mc_cnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  bit            c_st, c_mco;
  logic [SW-1:0] c_irs, c_irt, c_ers, c_ert;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      eval_all(c_st, c_mco, c_irs, c_irt, c_ers, c_ert);
      check("m_stall",     32'(stall),     32'(c_st));
      check("m_id_fwd_rs", 32'(id_fwd_rs), 32'(c_irs));
      check("m_id_fwd_rt", 32'(id_fwd_rt), 32'(c_irt));
      check("m_ex_fwd_rs", 32'(ex_fwd_rs), 32'(m_ex_rs));
      check("m_ex_fwd_rt", 32'(ex_fwd_rt), 32'(m_ex_rt));
      check("m_mc_busy",   32'(mc_busy),   32'(mc_pend));
`ifdef HAZARD_SCOREBOARD_STATS_EN
      check("m_stall_cnt",    stall_cnt,    m_stall_cnt);
      check("m_mc_stall_cnt", mc_stall_cnt, m_mc_cnt);
`endif
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit early,
                        input bit we, input int wr, input int av, input bit mul);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt);
    id_rs_use = (rs != 0); id_rt_use = (rt != 0); id_early = early;
    id_wr_en = we; id_wr_reg = AW'(wr); id_avail = SW'(av); id_multi = mul;
  endtask

  task automatic bubble();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    bubble();
    repeat (DEPTH) nxt();
  endtask

  task automatic rand_inputs();
    id_valid  = ($urandom_range(9) < 8);
    id_rs     = AW'($urandom_range(7));
    id_rt     = AW'($urandom_range(7));
    id_rs_use = ($urandom_range(3) != 0);
    id_rt_use = ($urandom_range(1) != 0);
    id_early  = ($urandom_range(3) == 0);
    id_wr_en  = ($urandom_range(9) < 7);
    id_wr_reg = AW'($urandom_range(7));
    id_avail  = SW'($urandom_range(DEPTH - 1));
    id_multi  = ($urandom_range(9) == 0);
    flush     = ($urandom_range(19) == 0);
    mc_done   = ($urandom_range(6) == 0);
  endtask

  initial begin
    rst = 1'b0; flush = 0; mc_done = 0;
    bubble();
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_ex_fwd_rs", 32'(ex_fwd_rs), 0);
    check("rst_id_fwd_rs", 32'(id_fwd_rs), 0);
    check("rst_mc_busy", 32'(mc_busy), 0);
    nxt(); rst = 1'b1;
    drain();

    // ALU to ALU
    set_id(1, 0, 0, 0, 1, 3, 0, 0); nxt();
    set_id(1, 3, 0, 0, 1, 4, 0, 0);
    @(negedge clk); check("alu_alu_stall", 32'(stall), 0);
    nxt(); bubble();
    @(negedge clk); check("alu_alu_ex_fwd", 32'(ex_fwd_rs), 2);
    drain();

    // Load-use
    set_id(1, 0, 0, 0, 1, 5, 1, 0); nxt();
    set_id(1, 5, 0, 0, 1, 6, 0, 0);
    @(negedge clk); check("load_use_stall", 32'(stall), 1);
    nxt();
    @(negedge clk); check("load_use_release", 32'(stall), 0);
    nxt(); bubble();
    @(negedge clk); check("load_use_ex_fwd", 32'(ex_fwd_rs), 3);
    drain();

    // Early branch after ALU, then branch on r0
    set_id(1, 0, 0, 0, 1, 3, 0, 0); nxt();
    set_id(1, 3, 0, 1, 0, 0, 0, 0);
    @(negedge clk); check("early_stall", 32'(stall), 1);
    nxt();
    @(negedge clk); check("early_release", 32'(stall), 0);
    check("early_id_fwd", 32'(id_fwd_rs), 2);
    nxt();
    set_id(1, 0, 0, 0, 1, 0, 0, 0); nxt();
    set_id(1, 0, 0, 1, 0, 0, 0, 0); id_rs_use = 1;
    @(negedge clk); check("r0_branch_stall", 32'(stall), 0);
    check("r0_branch_fwd", 32'(id_fwd_rs), 0);
    drain();

    // Multicycle dependency and second mul while busy
    set_id(1, 0, 0, 0, 1, 8, 0, 1); nxt();
    set_id(1, 8, 0, 0, 1, 9, 0, 0);
    @(negedge clk); check("mul_dep_stall", 32'(stall), 1);
    check("mul_busy", 32'(mc_busy), 1);
    repeat (2) begin nxt(); @(negedge clk); check("mul_dep_hold", 32'(stall), 1); end
    nxt(); mc_done = 1;
    @(negedge clk); check("mul_done_no_stall", 32'(stall), 0);
    nxt(); mc_done = 0;
    set_id(1, 0, 0, 0, 1, 8, 0, 1);
    @(negedge clk); check("mul_cleared", 32'(mc_busy), 0);
    nxt();
    set_id(1, 0, 0, 0, 1, 9, 0, 1);
    @(negedge clk); check("mul_unit_stall", 32'(stall), 1);
    nxt(); mc_done = 1;
    @(negedge clk); check("mul_unit_free", 32'(stall), 0);
    nxt(); mc_done = 0; bubble();
    @(negedge clk); check("mul2_busy", 32'(mc_busy), 1);
    nxt(); mc_done = 1; nxt(); mc_done = 0;
    @(negedge clk); check("mul2_cleared", 32'(mc_busy), 0);
    drain();

    // Flush during stall sets no busy bit
    set_id(1, 0, 0, 0, 1, 5, 1, 0); nxt();
    set_id(1, 5, 0, 0, 1, 9, 0, 1); flush = 1;
    @(negedge clk); check("flush_stall", 32'(stall), 1);
    nxt(); flush = 0; bubble();
    @(negedge clk); check("flush_no_busy", 32'(mc_busy), 0);
    drain();

    // Asynchronous reset in the middle of a multicycle op
    set_id(1, 0, 0, 0, 1, 8, 0, 1); nxt();
    set_id(1, 8, 0, 0, 1, 9, 0, 0);
    @(negedge clk); check("pre_rst_stall", 32'(stall), 1);
    #2 rst = 1'b0;
    #1 check("async_rst_stall", 32'(stall), 0);
    check("async_rst_mc_busy", 32'(mc_busy), 0);
    nxt(); rst = 1'b1;
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      nxt();
    end
    flush = 0; mc_done = 0;
    drain();

`ifdef HAZARD_SCOREBOARD_STATS_EN
    rst = 1'b0; nxt(); rst = 1'b1;
    for (int p = 0; p < 5; p++) begin
      set_id(1, 0, 0, 0, 1, 5, 1, 0); nxt();
      set_id(1, 5, 0, 0, 1, 6, 0, 0); nxt(); nxt();
    end
    drain();
    @(negedge clk); check("stats_load_use", stall_cnt, 5);
    nxt();
    set_id(1, 0, 0, 0, 1, 8, 0, 1); nxt();
    set_id(1, 8, 0, 0, 1, 9, 0, 0);
    repeat (10) nxt();
    mc_done = 1;
    @(negedge clk); check("stats_done_no_stall", 32'(stall), 0);
    nxt(); mc_done = 0; bubble();
    @(negedge clk); check("stats_mc_stall", mc_stall_cnt, 10);
    check("stats_total", stall_cnt, 15);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
